// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin, packet-locking arbiter for one router output port
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous, active-high
//   req        per-input request for this output (head-of-line flit routed here)
//   tail       per-input tail marker for the head-of-line flit, qualified by req
//   out_ready  downstream accepts a flit this cycle
//   grant      registered one-hot owner, or zero when idle
//   sel        registered binary owner index for the crossbar mux
//   busy       registered lock indicator (== |grant)
//   xfer       combinational: owner's flit moves this cycle
module output_port_arbiter #(
    parameter int N_IN  = 5,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  req,
    input  logic [N_IN-1:0]  tail,
    input  logic             out_ready,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             xfer
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic             owner_tail;

    // Cyclic scan starting at ptr; the first requester found wins.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    // grant is one-hot, so masking picks out the owner's bits without indexing by sel.
    assign xfer       = (|(grant & req)) & out_ready;
    assign owner_tail = |(grant & tail);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= LOCKED;
                        grant <= N_IN'(1) << winner;
                        sel   <= winner;
                        busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    // Only a completed packet releases the port and rotates priority.
                    if (xfer && owner_tail) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= (sel == SEL_W'(N_IN - 1)) ? '0 : sel + SEL_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Round-robin, packet-locking arbiter that shares one output port of a NoC router node (`node3`/`node4`/`node5`) among its input ports. One instance sits per output port inside a node and drives the crossbar select for that port. Once an input wins, it holds the port until its tail flit transfers (wormhole), then priority rotates past it.

## Interface
Parameters:
- `N_IN`, 5, number of competing input ports (3..5 in nodes; any value ≥1 legal)
- `SEL_W`, max(1, $clog2(N_IN)), width of `sel`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  N_IN  bit i: input i's head-of-line flit is routed to this output
- `tail`  in  N_IN  bit i: input i's head-of-line flit is a tail (single-flit packet has head and tail together); qualified by `req[i]`
- `out_ready`  in  1  downstream accepts a flit this cycle
- `grant`  out  N_IN  one-hot owner of the port, or all zero; registered
- `sel`  out  SEL_W  binary index of owner, for crossbar mux; registered
- `busy`  out  1  port locked to an owner (== |grant); registered
- `xfer`  out  1  flit moves this cycle = |(grant & req) & out_ready; combinational

## Operation
- State: IDLE, LOCKED; internal priority pointer `ptr` (0..N_IN-1).
- IDLE: if `req` ≠ 0, winner = first i with `req[i]`, scanning ptr, ptr+1, …, N_IN-1, 0, … (cyclic). Next edge: LOCKED, `grant` = onehot(winner), `sel` = winner, `busy` = 1. If `req` = 0, stay IDLE.
- LOCKED: owner = `sel`. `xfer` = `req[owner]` & `out_ready`.
  - `xfer` & `tail[owner]`: next edge IDLE, `grant` = 0, `busy` = 0, `ptr` = (owner+1) mod N_IN (N_IN-1 wraps to 0). `sel` holds its last value.
  - Otherwise stay LOCKED, all outputs hold.
- Requests from non-owners are ignored while LOCKED; they take no effect until the next IDLE cycle.
- Owner `req` dropping mid-packet (upstream bubble): no transfer, lock held indefinitely.
- `out_ready` low: no transfer, lock held.
- `ptr` updates only on tail transfer. Winning without completing a packet does not rotate priority.
- `tail` of non-owners and `tail[owner]` without `xfer` are ignored.

## Timing
- Reset (sync, checked at edge): state IDLE, `grant` = 0, `sel` = 0, `busy` = 0, `ptr` = 0, so `xfer` = 0 from the first post-reset cycle. Reset mid-packet aborts the lock on that edge. The packet remainder is upstream's concern.
- Arbitration latency: `req` seen in IDLE in cycle t gives `grant` valid in cycle t+1. The earliest flit transfer is in t+1.
- Tail transfer in cycle t gives IDLE in t+1 and a new grant in t+2. There is exactly one dead cycle between packets on a port.
- Single-flit packet with `out_ready` = 1 occupies the port for 2 cycles (arbitrate + transfer).
- `grant`/`sel`/`busy` are glitch-free registers. `xfer` is the only combinational output and depends on `req`, `out_ready` and registered `grant`.
- Invariants: `grant` is one-hot or zero; `busy` == |grant; `grant[sel]` == 1 whenever `busy`.

## Test plan
- Reset then idle: `req`=0 for 10 cycles -> `grant`=0, `busy`=0, `xfer`=0 throughout; assert `reset` mid-LOCKED -> `grant`=0 the next cycle, `ptr` back to 0.
- Single requester, 4-flit packet, N_IN=5: `req`=5'b00100, `out_ready`=1, `tail` on 4th flit -> `grant`=00100 and `sel`=2 one cycle after `req`; `xfer` high 4 cycles; `grant`=0 the cycle after the tail.
- Round-robin fairness: all 5 `req` held high, single-flit packets -> grant order 0,1,2,3,4,0,… with one idle cycle between grants.
- Lock hold: input 1 owns the port, input 0 requests mid-packet -> `grant` stays 00010 until input 1's tail transfers; then input 2 wins if requesting, else 3, 4, 0.
- Backpressure/bubble: `out_ready`=0 for 3 cycles, then owner `req`=0 for 2 cycles mid-packet -> `xfer`=0 during both, `grant` unchanged, no flit lost; transfer resumes when both are high.
- Wrap: ptr=4 (after input 3's tail), `req`=5'b10001 -> input 4 wins; after its tail, input 0 wins.
